// File: rtl/avalon_st_framer_pkg.sv
// Shared types and framing arithmetic for the Avalon-ST transmit framer.
package avalon_st_framer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } framer_state_t;

  typedef struct packed {
    logic [31:0] words;
    logic [31:0] empty;
  } framing_t;

  function automatic int empty_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // Word count rounds the byte length up; empty is the unused tail of the last word.
  function automatic framing_t calc_framing(input int unsigned len, input int unsigned w);
    framing_t fr;
    fr.words = (len + w - 1) / w;
    fr.empty = fr.words * w - len;
    return fr;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST streaming bundle; the master drives everything except rdy.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EMPTY_WIDTH = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic                             valid;
  logic                             rdy;
  logic                             sop;
  logic                             eop;
  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic [EMPTY_WIDTH-1:0]           empty;

  modport master (output valid, sop, eop, data, empty, input rdy);
  modport slave  (input valid, sop, eop, data, empty, output rdy);

endinterface

// File: rtl/avalon_st_byte_mask.sv
// Combinational zero-pad of the final word; used with AVALON_ST_FRAMER_ZERO_PAD_EN.
module avalon_st_byte_mask
  import avalon_st_framer_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 16
) (
  input  logic [8*DATA_WIDTH_IN_BYTES-1:0]             data_i,
  input  logic [empty_width(DATA_WIDTH_IN_BYTES)-1:0]  empty_i,
  output logic [8*DATA_WIDTH_IN_BYTES-1:0]             data_o
);

  // Byte 0 sits at the MSB, so the unused tail bytes are the least significant ones.
  always_comb begin
    data_o = data_i;
    for (int k = 0; k < DATA_WIDTH_IN_BYTES; k++) begin
      if (k < int'(empty_i)) begin
        data_o[8*k +: 8] = 8'h00;
      end
    end
  end

endmodule

// File: rtl/avalon_st_framer.sv
// Frames an unframed word stream into Avalon-ST packets from byte-length descriptors.
// Define AVALON_ST_FRAMER_ZERO_PAD_EN to zero the unused bytes of each eop word.
module avalon_st_framer
  import avalon_st_framer_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int LEN_WIDTH           = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             len_valid,
  input  logic [LEN_WIDTH-1:0]             len_bytes,
  output logic                             len_rdy,
  input  logic                             raw_valid,
  input  logic [8*DATA_WIDTH_IN_BYTES-1:0] raw_data,
  output logic                             raw_rdy,
  avalon_st_if.master                      framed_msg,
  output logic                             len_err
);

  localparam int W  = DATA_WIDTH_IN_BYTES;
  localparam int EW = empty_width(DATA_WIDTH_IN_BYTES);

  framer_state_t        state_q, state_d;
  logic [LEN_WIDTH-1:0] words_left_q, words_left_d;
  logic [EW-1:0]        last_empty_q, last_empty_d;
  logic                 first_q, first_d;
  logic                 len_err_q, len_err_d;

  framing_t             len_fr;
  logic                 is_last;
  logic                 out_valid;
  logic                 out_sop;
  logic                 out_eop;
  logic [EW-1:0]        out_empty;
  logic [8*W-1:0]       out_data;

  assign len_fr  = calc_framing(32'(len_bytes), W);
  assign is_last = (words_left_q == LEN_WIDTH'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      words_left_q <= '0;
      last_empty_q <= '0;
      first_q      <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      last_empty_q <= last_empty_d;
      first_q      <= first_d;
      len_err_q    <= len_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    last_empty_d = last_empty_q;
    first_d      = first_q;
    len_err_d    = 1'b0;
    len_rdy      = 1'b0;
    raw_rdy      = 1'b0;
    out_valid    = 1'b0;
    out_sop      = 1'b0;
    out_eop      = 1'b0;
    out_empty    = '0;

    case (state_q)
      IDLE: begin
        len_rdy = 1'b1;
        if (len_valid) begin
          if (len_bytes == '0) begin
            len_err_d = 1'b1;
          end else begin
            words_left_d = LEN_WIDTH'(len_fr.words);
            last_empty_d = EW'(len_fr.empty);
            first_d      = 1'b1;
            state_d      = SEND;
          end
        end
      end
      SEND: begin
        // Raw side is a pass-through; only the framing fields come from registers.
        out_valid = raw_valid;
        raw_rdy   = framed_msg.rdy;
        out_sop   = raw_valid & first_q;
        out_eop   = raw_valid & is_last;
        out_empty = out_eop ? last_empty_q : '0;
        if (raw_valid && framed_msg.rdy) begin
          first_d      = 1'b0;
          words_left_d = words_left_q - LEN_WIDTH'(1);
          if (is_last) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef AVALON_ST_FRAMER_ZERO_PAD_EN
  avalon_st_byte_mask #(
    .DATA_WIDTH_IN_BYTES(W)
  ) u_byte_mask (
    .data_i (raw_data),
    .empty_i(out_empty),
    .data_o (out_data)
  );
`else
  assign out_data = raw_data;
`endif

  assign framed_msg.valid = out_valid;
  assign framed_msg.sop   = out_sop;
  assign framed_msg.eop   = out_eop;
  assign framed_msg.empty = out_empty;
  assign framed_msg.data  = out_data;
  assign len_err          = len_err_q;

endmodule

// File: tb/tb_avalon_st_framer.sv
// Self-checking bench for avalon_st_framer (W=16); honours AVALON_ST_FRAMER_ZERO_PAD_EN.
module tb_avalon_st_framer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         len_valid = 1'b0;
  logic [15:0]  len_bytes = '0;
  logic         len_rdy;
  logic         raw_valid = 1'b0;
  logic [127:0] raw_data;
  logic         raw_rdy;
  logic         len_err;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(W)) framedIf ();

  avalon_st_framer #(
    .DATA_WIDTH_IN_BYTES(W),
    .LEN_WIDTH          (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .len_valid (len_valid),
    .len_bytes (len_bytes),
    .len_rdy   (len_rdy),
    .raw_valid (raw_valid),
    .raw_data  (raw_data),
    .raw_rdy   (raw_rdy),
    .framed_msg(framedIf),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit active  = 1'b0;
  int curLen  = 0;
  int wordIdx = 0;
  bit errExp  = 1'b0;

  int           obsWords = 0;
  int           obsSop = 0;
  int           obsEop = 0;
  int           errCount = 0;
  int           lastEmptyObs = 0;
  logic [127:0] lastEopData = '0;
  logic [7:0]   prevSeq = '0;
  logic [7:0]   sopSeq = '0;

  int rawSeq     = 1;
  bit rawFire    = 1'b0;
  bit rdyToggle  = 1'b0;

  int w0, s0, e0, err0;

  // Byte 0 carries a running sequence number; the other bytes are fixed and nonzero.
  function automatic logic [127:0] mkWord(input int seq);
    logic [127:0] w;
    for (int b = 0; b < W; b++) begin
      w[127-8*b -: 8] = (b == 0) ? 8'(seq) : 8'(8'hA0 + b);
    end
    return w;
  endfunction

  function automatic logic [127:0] padWord(input logic [127:0] w, input int emp);
    logic [127:0] r;
    r = w;
`ifdef AVALON_ST_FRAMER_ZERO_PAD_EN
    for (int k = 0; k < emp; k++) begin
      r[8*k +: 8] = 8'h00;
    end
`endif
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int len);
    @(posedge clk); #1;
    len_valid = 1'b1;
    len_bytes = 16'(len);
    @(posedge clk); #1;
    len_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (active && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (active) begin
      total++;
      bad++;
      $display("[TB] FAIL waitIdle: packet still open after %0d cycles", budget);
    end
  endtask

  task automatic snap();
    w0   = obsWords;
    s0   = obsSop;
    e0   = obsEop;
    err0 = errCount;
  endtask

  // Packet-level model: a descriptor opens a packet of ceil(len/W) words, each output handshake advances it.
  always @(negedge clk) begin : compareProc
    int nw;
    int emp;
    bit expValid;
    bit isLast;
    if (!rst) begin
      checkOutput("rst_valid", framedIf.valid, 0);
      checkOutput("rst_len_rdy", len_rdy, 1);
      checkOutput("rst_raw_rdy", raw_rdy, 0);
      checkOutput("rst_len_err", len_err, 0);
      active  = 1'b0;
      errExp  = 1'b0;
      curLen  = 0;
      wordIdx = 0;
    end else begin
      nw       = (curLen + W - 1) / W;
      isLast   = active && (wordIdx == nw - 1);
      emp      = isLast ? (nw * W - curLen) : 0;
      expValid = active && raw_valid;

      checkOutput("valid", framedIf.valid, expValid);
      checkOutput("len_rdy", len_rdy, !active);
      checkOutput("raw_rdy", raw_rdy, active && framedIf.rdy);
      checkOutput("len_err", len_err, errExp);
      checkOutput("sop", framedIf.sop, expValid && (wordIdx == 0));
      checkOutput("eop", framedIf.eop, expValid && isLast);
      checkOutput("empty", framedIf.empty, expValid ? emp : 0);
      if (expValid) checkOutput("data", framedIf.data, padWord(raw_data, emp));

      if (len_err) errCount++;
      if (framedIf.valid && framedIf.rdy) begin
        obsWords++;
        if (framedIf.sop) begin
          obsSop++;
          sopSeq = framedIf.data[127:120];
        end else begin
          checkOutput("seq", framedIf.data[127:120], 8'(prevSeq + 1));
        end
        prevSeq = framedIf.data[127:120];
        if (framedIf.eop) begin
          obsEop++;
          lastEmptyObs = int'(framedIf.empty);
          lastEopData  = framedIf.data;
        end
      end

      errExp = 1'b0;
      if (!active) begin
        if (len_valid) begin
          if (len_bytes == 16'd0) begin
            errExp = 1'b1;
          end else begin
            active  = 1'b1;
            curLen  = int'(len_bytes);
            wordIdx = 0;
          end
        end
      end else if (raw_valid && framedIf.rdy) begin
        if (isLast) active = 1'b0;
        else wordIdx++;
      end
    end
  end

  initial begin
    raw_data = mkWord(rawSeq);
    forever begin
      @(negedge clk);
      rawFire = raw_valid && raw_rdy && rst;
      @(posedge clk); #1;
      if (rawFire) rawSeq++;
      raw_data = mkWord(rawSeq);
    end
  end

  initial begin
    framedIf.rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdyToggle) framedIf.rdy = ~framedIf.rdy;
      else framedIf.rdy = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("init_len_rdy", len_rdy, 1);
    checkOutput("init_valid", framedIf.valid, 0);
    checkOutput("init_raw_rdy", raw_rdy, 0);

    $display("[TB] 64-byte packet, rdy high");
    raw_valid = 1'b1;
    snap();
    applyStimulus(64);
    waitIdle(100);
    checkOutput("t64_words", obsWords - w0, 4);
    checkOutput("t64_sop", obsSop - s0, 1);
    checkOutput("t64_eop", obsEop - e0, 1);
    checkOutput("t64_empty", lastEmptyObs, 0);

    $display("[TB] 5-byte single-word packet");
    snap();
    applyStimulus(5);
    waitIdle(100);
    checkOutput("t5_words", obsWords - w0, 1);
    checkOutput("t5_sop", obsSop - s0, 1);
    checkOutput("t5_eop", obsEop - e0, 1);
    checkOutput("t5_empty", lastEmptyObs, 11);
`ifdef AVALON_ST_FRAMER_ZERO_PAD_EN
    checkOutput("t5_tail", lastEopData[87:0], 88'h0);
`else
    checkOutput("t5_tail", lastEopData[87:0], 88'hA5A6A7A8A9AAABACADAEAF);
`endif

    $display("[TB] 33-byte packet, rdy toggling");
    rdyToggle = 1'b1;
    snap();
    applyStimulus(33);
    waitIdle(200);
    rdyToggle = 1'b0;
    checkOutput("t33_words", obsWords - w0, 3);
    checkOutput("t33_eop", obsEop - e0, 1);
    checkOutput("t33_empty", lastEmptyObs, 15);
    checkOutput("t33_span", 8'(lastEopData[127:120] - sopSeq), 2);

    $display("[TB] zero-length descriptor");
    snap();
    applyStimulus(0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t0_err_pulses", errCount - err0, 1);
    checkOutput("t0_words", obsWords - w0, 0);
    snap();
    applyStimulus(16);
    waitIdle(100);
    checkOutput("t0_next_words", obsWords - w0, 1);

    $display("[TB] reset mid-packet");
    snap();
    applyStimulus(64);
    n = 0;
    while ((obsWords - w0) < 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("tr_reached_word2", obsWords - w0, 2);
    #2 rst = 1'b0;
    #1;
    checkOutput("tr_valid", framedIf.valid, 0);
    checkOutput("tr_sop", framedIf.sop, 0);
    checkOutput("tr_eop", framedIf.eop, 0);
    checkOutput("tr_empty", framedIf.empty, 0);
    checkOutput("tr_raw_rdy", raw_rdy, 0);
    e0 = obsEop;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("tr_no_stray_eop", obsEop - e0, 0);
    snap();
    applyStimulus(16);
    waitIdle(100);
    checkOutput("tr_new_words", obsWords - w0, 1);
    checkOutput("tr_new_sop", obsSop - s0, 1);
    checkOutput("tr_new_eop", obsEop - e0, 1);
    checkOutput("tr_new_empty", lastEmptyObs, 0);

    $display("[TB] raw valid in IDLE without descriptor");
    raw_valid = 1'b1;
    snap();
    repeat (10) @(posedge clk);
    #1;
    checkOutput("tidle_words", obsWords - w0, 0);
    checkOutput("tidle_raw_rdy", raw_rdy, 0);
    checkOutput("tidle_valid", framedIf.valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
